// File: rtl/ffram_pkg.sv
// ffram_pkg: shared definitions for the ffram port controller.
//   - default geometry (ADDR_W, DATA_W) and sweep fill value (INIT_VAL)
//   - FSM state encoding used by ffram_port_ctrl
package ffram_pkg;

  localparam int unsigned DEF_ADDR_W   = 1;
  localparam int unsigned DEF_DATA_W   = 1;
  localparam int unsigned DEF_INIT_VAL = 0;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_INIT    = 3'd0;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_WV_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_WV_CHK  = 3'd4;

endpackage

// File: rtl/ffram_rsp_buf.sv
// ffram_rsp_buf: single-entry valid/ready response register.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cap, cap_data  load a new response (wins over a same-edge drain)
//   rsp_ready      consumer takes the held response
//   rsp_valid      response held
//   rsp_rdata      held response data (stable until taken)
module ffram_rsp_buf
  import ffram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // Drain on handshake; a capture on the same edge keeps the entry full.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (cap) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: rtl/ffram_port_ctrl.sv
// ffram_port_ctrl: request/response front-end for the single-port ffram.
// After reset it writes INIT_VAL to every location, then serialises
// valid/ready read/write requests onto the RAM port and returns read data
// through a single-entry back-pressurable response buffer.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_wen, req_addr, req_wdata    request payload (1 = write)
//   rsp_valid/rsp_ready, rsp_rdata  read response handshake and data
//   init_done                       init sweep complete (sticky)
//   ram_addr, ram_wen, ram_din      RAM port drive
//   ram_dout                        RAM registered read data
//   verify_err                      sticky write read-back mismatch
//                                   (only with FFRAM_PORT_CTRL_WRITE_VERIFY_EN)
// Optional feature macro: FFRAM_PORT_CTRL_WRITE_VERIFY_EN adds an automatic
// read-back check after every accepted write.
module ffram_port_ctrl
  import ffram_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DEF_ADDR_W,
  parameter int unsigned        DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
  ,
  output logic              verify_err
`endif
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  // Last driven RAM address/data, held while the port is idle.
  logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]  din_hold_q, din_hold_d;
  logic               fire;
  logic               cap;

`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
  logic [DATA_W-1:0]  wv_data_q, wv_data_d;
  logic               verify_err_q, verify_err_d;
`endif

  // FSM next state, sweep counter and RAM port drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    addr_hold_d = addr_hold_q;
    din_hold_d  = din_hold_q;
    ram_wen     = 1'b0;
    ram_addr    = addr_hold_q;
    ram_din     = din_hold_q;
    req_ready   = 1'b0;
    fire        = 1'b0;
    cap         = 1'b0;
`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
    wv_data_d    = wv_data_q;
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      ST_INIT: begin
        ram_wen     = 1'b1;
        ram_addr    = cnt_q[ADDR_W-1:0];
        ram_din     = INIT_VAL;
        addr_hold_d = cnt_q[ADDR_W-1:0];
        din_hold_d  = INIT_VAL;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end

      ST_IDLE: begin
        // Refuse new work only while a held response is not being taken.
        req_ready = !(rsp_valid && !rsp_ready);
        fire      = req_valid && req_ready;
        if (fire) begin
          ram_addr    = req_addr;
          ram_wen     = req_wen;
          ram_din     = req_wdata;
          addr_hold_d = req_addr;
          din_hold_d  = req_wdata;
          if (req_wen) begin
`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
            state_d   = ST_WV_WAIT;
            wv_data_d = req_wdata;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        // ram_dout now carries the read issued last cycle.
        cap     = 1'b1;
        state_d = ST_IDLE;
      end

`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
      ST_WV_WAIT: begin
        // Address held with wen low: the RAM reads back the written word.
        state_d = ST_WV_CHK;
      end

      ST_WV_CHK: begin
        if (ram_dout != wv_data_q) begin
          verify_err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Port is quiet while reset is asserted.
    if (reset) begin
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      req_ready = 1'b0;
      fire      = 1'b0;
      cap       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wv_data_q    <= '0;
      verify_err_q <= 1'b0;
    end else begin
      wv_data_q    <= wv_data_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign verify_err = verify_err_q;
`endif

  assign init_done = init_done_q;

  ffram_rsp_buf #(
    .DATA_W (DATA_W)
  ) u_rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .cap       (cap),
    .cap_data  (ram_dout),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_ffram_port_ctrl.sv
// tb_ffram_port_ctrl: directed bench for ffram_port_ctrl.
// Two instances, each with its own behavioural ffram: a 2x1 controller
// (INIT_VAL=1) for the minimal sweep, and a 4x8 controller (INIT_VAL=0xC3)
// for write/read, back-pressure, reset and optional write-verify cases.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ffram_port_ctrl;

  logic clk;
  logic reset;

  // Small instance: ADDR_W=1, DATA_W=1
  logic       s_req_valid, s_req_ready, s_req_wen;
  logic [0:0] s_req_addr;
  logic [0:0] s_req_wdata;
  logic       s_rsp_valid, s_rsp_ready;
  logic [0:0] s_rsp_rdata;
  logic       s_init_done, s_ram_wen;
  logic [0:0] s_ram_addr, s_ram_din, s_ram_dout;
  logic [0:0] s_mem [2];

  // Big instance: ADDR_W=2, DATA_W=8
  logic       b_req_valid, b_req_ready, b_req_wen;
  logic [1:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid, b_rsp_ready;
  logic [7:0] b_rsp_rdata;
  logic       b_init_done, b_ram_wen;
  logic [1:0] b_ram_addr;
  logic [7:0] b_ram_din, b_ram_dout;
  logic [7:0] b_mem [4];
  logic       corrupt;

`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
  logic s_verify_err, b_verify_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ffram_port_ctrl #(
    .ADDR_W   (1),
    .DATA_W   (1),
    .INIT_VAL (1'b1)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (s_req_valid),
    .req_ready  (s_req_ready),
    .req_wen    (s_req_wen),
    .req_addr   (s_req_addr),
    .req_wdata  (s_req_wdata),
    .rsp_valid  (s_rsp_valid),
    .rsp_ready  (s_rsp_ready),
    .rsp_rdata  (s_rsp_rdata),
    .init_done  (s_init_done),
    .ram_addr   (s_ram_addr),
    .ram_wen    (s_ram_wen),
    .ram_din    (s_ram_din),
    .ram_dout   (s_ram_dout)
`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
    ,
    .verify_err (s_verify_err)
`endif
  );

  ffram_port_ctrl #(
    .ADDR_W   (2),
    .DATA_W   (8),
    .INIT_VAL (8'hC3)
  ) u_big (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_wen    (b_req_wen),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (b_rsp_ready),
    .rsp_rdata  (b_rsp_rdata),
    .init_done  (b_init_done),
    .ram_addr   (b_ram_addr),
    .ram_wen    (b_ram_wen),
    .ram_din    (b_ram_din),
    .ram_dout   (b_ram_dout)
`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
    ,
    .verify_err (b_verify_err)
`endif
  );

  // Behavioural ffram: registered dout, write-through on writes.
  always @(posedge clk) begin
    if (s_ram_wen) begin
      s_mem[s_ram_addr] <= s_ram_din;
      s_ram_dout        <= s_ram_din;
    end else begin
      s_ram_dout <= s_mem[s_ram_addr];
    end
  end

  // Same model; 'corrupt' flips bit 0 of the stored word on a write.
  always @(posedge clk) begin
    if (b_ram_wen) begin
      b_mem[b_ram_addr] <= b_ram_din ^ (corrupt ? 8'h01 : 8'h00);
      b_ram_dout        <= b_ram_din ^ (corrupt ? 8'h01 : 8'h00);
    end else begin
      b_ram_dout <= b_mem[b_ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic b_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_wen   = 1'b1;
    b_req_addr  = a;
    b_req_wdata = d;
    #1;
    chk("wr_ready", 32'(b_req_ready), 32'd1);
    chk("wr_wen",   32'(b_ram_wen),   32'd1);
    chk("wr_addr",  32'(b_ram_addr),  32'(a));
    chk("wr_din",   32'(b_ram_din),   32'(d));
`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
    @(negedge clk);
    b_req_valid = 1'b0;
    #1;
    chk("wv_wait_ready", 32'(b_req_ready), 32'd0);
    chk("wv_wait_wen",   32'(b_ram_wen),   32'd0);
    chk("wv_wait_addr",  32'(b_ram_addr),  32'(a));
    @(negedge clk);
    #1;
    chk("wv_chk_ready", 32'(b_req_ready), 32'd0);
    chk("wv_chk_rspv",  32'(b_rsp_valid), 32'd0);
`endif
  endtask

  task automatic b_rd(input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_wen   = 1'b0;
    b_req_addr  = a;
    #1;
    chk("rd_ready", 32'(b_req_ready), 32'd1);
    chk("rd_wen",   32'(b_ram_wen),   32'd0);
    chk("rd_addr",  32'(b_ram_addr),  32'(a));
    @(negedge clk);
    b_req_valid = 1'b0;
    #1;
    chk("rd_wait_rspv",  32'(b_rsp_valid), 32'd0);
    chk("rd_wait_ready", 32'(b_req_ready), 32'd0);
    chk("rd_wait_addr",  32'(b_ram_addr),  32'(a));
    @(negedge clk);
    #1;
    chk("rd_rspv", 32'(b_rsp_valid), 32'd1);
    chk("rd_data", 32'(b_rsp_rdata), 32'(exp));
  endtask

  initial begin
    logic [7:0] wdat [4];
    wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1;
    corrupt = 1'b0;
    s_req_valid = 1'b0; s_req_wen = 1'b0; s_req_addr = '0; s_req_wdata = '0;
    s_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) s_mem[i] = 1'b0;
    for (int i = 0; i < 4; i++) b_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_wen",   32'(s_ram_wen),   32'd0);
    chk("rst_s_ready", 32'(s_req_ready), 32'd0);
    chk("rst_s_done",  32'(s_init_done), 32'd0);
    chk("rst_s_rspv",  32'(s_rsp_valid), 32'd0);
    chk("rst_b_addr",  32'(b_ram_addr),  32'd0);
    chk("rst_b_din",   32'(b_ram_din),   32'd0);
    chk("rst_b_rdata", 32'(b_rsp_rdata), 32'd0);

    // Init sweep: small finishes in 2 cycles, big in 4
    reset = 1'b0;
    #1;
    chk("s_init0_wen",   32'(s_ram_wen),   32'd1);
    chk("s_init0_addr",  32'(s_ram_addr),  32'd0);
    chk("s_init0_din",   32'(s_ram_din),   32'd1);
    chk("s_init0_ready", 32'(s_req_ready), 32'd0);
    chk("b_init0_din",   32'(b_ram_din),   32'hC3);
    @(negedge clk); #1;
    chk("s_init1_wen",  32'(s_ram_wen),   32'd1);
    chk("s_init1_addr", 32'(s_ram_addr),  32'd1);
    chk("s_init1_done", 32'(s_init_done), 32'd0);
    chk("b_init1_addr", 32'(b_ram_addr),  32'd1);
    @(negedge clk); #1;
    chk("s_done",       32'(s_init_done), 32'd1);
    chk("s_idle_wen",   32'(s_ram_wen),   32'd0);
    chk("b_init2_addr", 32'(b_ram_addr),  32'd2);
    chk("b_init2_wen",  32'(b_ram_wen),   32'd1);
    chk("b_init2_done", 32'(b_init_done), 32'd0);
    @(negedge clk); #1;
    chk("b_init3_addr", 32'(b_ram_addr),  32'd3);
    chk("b_init3_wen",  32'(b_ram_wen),   32'd1);
    @(negedge clk); #1;
    chk("b_done",       32'(b_init_done), 32'd1);
    chk("b_idle_ready", 32'(b_req_ready), 32'd1);
    chk("b_idle_wen",   32'(b_ram_wen),   32'd0);

    // Small instance: both locations read back INIT_VAL
    for (int a = 0; a < 2; a++) begin
      @(negedge clk);
      s_req_valid = 1'b1;
      s_req_addr  = 1'(a);
      #1;
      chk("s_rd_ready", 32'(s_req_ready), 32'd1);
      @(negedge clk);
      s_req_valid = 1'b0;
      #1;
      chk("s_rd_wait_rspv", 32'(s_rsp_valid), 32'd0);
      @(negedge clk); #1;
      chk("s_rd_rspv", 32'(s_rsp_valid), 32'd1);
      chk("s_rd_data", 32'(s_rsp_rdata), 32'd1);
    end

    // Write then next-cycle read of the same address
    b_wr(2'd2, 8'hA5);
    b_rd(2'd2, 8'hA5);

    // Back-pressure: response held, no new accepts
    b_wr(2'd1, 8'h3C);
    @(negedge clk);
    b_rsp_ready = 1'b0;
    b_req_valid = 1'b1;
    b_req_wen   = 1'b0;
    b_req_addr  = 2'd1;
    #1;
    chk("bp_accept", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    #1;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_rspv",  32'(b_rsp_valid), 32'd1);
      chk("bp_hold_data",  32'(b_rsp_rdata), 32'h3C);
      chk("bp_hold_ready", 32'(b_req_ready), 32'd0);
      @(negedge clk); #1;
    end
    b_rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk); #1;
    chk("bp_drained_rspv", 32'(b_rsp_valid), 32'd0);

    // Back-to-back writes, then in-order reads
    for (int i = 0; i < 4; i++) b_wr(2'(i), wdat[i]);
    for (int i = 0; i < 4; i++) b_rd(2'(i), wdat[i]);

    // Reset while a read is in flight
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_wen   = 1'b0;
    b_req_addr  = 2'd3;
    #1;
    chk("rm_accept", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rm_rst_wen",   32'(b_ram_wen),   32'd0);
    chk("rm_rst_ready", 32'(b_req_ready), 32'd0);
    @(negedge clk); #1;
    chk("rm_rspv", 32'(b_rsp_valid), 32'd0);
    chk("rm_done", 32'(b_init_done), 32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rm_sweep_wen",  32'(b_ram_wen),  32'd1);
      chk("rm_sweep_addr", 32'(b_ram_addr), 32'(i));
      chk("rm_sweep_din",  32'(b_ram_din),  32'hC3);
      chk("rm_sweep_rspv", 32'(b_rsp_valid), 32'd0);
      @(negedge clk); #1;
    end
    chk("rm_done_again", 32'(b_init_done), 32'd1);
    b_rd(2'd0, 8'hC3);
    b_rd(2'd3, 8'hC3);

`ifdef FFRAM_PORT_CTRL_WRITE_VERIFY_EN
    // Clean write leaves verify_err low
    chk("wv_clean_pre", 32'(b_verify_err), 32'd0);
    b_wr(2'd1, 8'h5A);
    @(negedge clk); #1;
    chk("wv_clean", 32'(b_verify_err), 32'd0);
    // Corrupted write flags verify_err at N+3, sticky afterwards
    corrupt = 1'b1;
    b_wr(2'd0, 8'h0F);
    corrupt = 1'b0;
    @(negedge clk); #1;
    chk("wv_err_set", 32'(b_verify_err), 32'd1);
    chk("wv_err_rspv", 32'(b_rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("wv_err_sticky", 32'(b_verify_err), 32'd1);
    end
    b_rd(2'd1, 8'h5A);
    chk("wv_err_after_rd", 32'(b_verify_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
